parc_core_muldiv_arb: RTL and testbench

Shares the single pipelined multiply/divide unit between the two issue lanes of the dual-fetch PARC core. Arbitrates per cycle between lane 0 and lane 1 requests and forwards the granted operation to the muldiv unit. Records the granted lane in an in-order tag queue, then steers each muldiv response back to the lane that issued it. It sits between the two X-stage muldiv request points and `parc_CoreDpathPipeMulDiv`.

---
 rtl/parc_core_muldiv_arb_pkg.sv | 33 +++
 rtl/parc_core_muldiv_arb_tagq.sv | 75 +++++++
 rtl/parc_core_muldiv_arb.sv | 140 ++++++++++++++
 tb/tb_parc_core_muldiv_arb.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parc_core_muldiv_arb_pkg.sv
// ---------------------------------------------------------------------------
// parc_core_muldiv_arb_pkg
//
// Shared definitions for the dual-lane muldiv arbiter:
//   - muldiv function codes driven on reqN_fn / muldivreq_msg_fn
//   - lane-ID width and the two lane IDs recorded in the tag queue
//   - layout of the 64-bit muldiv response (rem/hi upper, quo/lo lower)
// ---------------------------------------------------------------------------
package parc_core_muldiv_arb_pkg;

    typedef enum logic [2:0] {
        MD_MUL  = 3'd0,
        MD_DIV  = 3'd1,
        MD_DIVU = 3'd2,
        MD_REM  = 3'd3,
        MD_REMU = 3'd4
    } muldiv_fn_e;

    localparam int LANE_W = 1;

    typedef logic [LANE_W-1:0] lane_id_t;

    localparam lane_id_t LANE0 = 1'b0;
    localparam lane_id_t LANE1 = 1'b1;

    // Response word: remainder (div/rem) or high product (mul) in the upper
    // half, quotient or low product in the lower half.
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } muldiv_resp_t;

endpackage

// File: rtl/parc_core_muldiv_arb_tagq.sv
// ---------------------------------------------------------------------------
// parc_core_muldiv_arb_tagq
//
// In-order queue of lane IDs for muldiv operations in flight. Circular
// buffer of DEPTH entries with wrapping read/write pointers and an explicit
// occupancy count. A push while full is dropped even if a pop happens in the
// same cycle; a pop while empty is ignored.
//
// Ports:
//   clk, reset_n        core clock, asynchronous active-low reset
//   push, push_id       enqueue the lane ID of an issued operation
//   pop                 dequeue the head (response accepted)
//   full, empty         occupancy flags
//   head                lane ID of the oldest outstanding operation
// ---------------------------------------------------------------------------
module parc_core_muldiv_arb_tagq
    import parc_core_muldiv_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push,
    input  lane_id_t push_id,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output lane_id_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    lane_id_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: the storage is only DEPTH single-bit entries, so it is
            // reset as well; head is then never undefined, even when empty.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= LANE0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/parc_core_muldiv_arb.sv
// ---------------------------------------------------------------------------
// parc_core_muldiv_arb
//
// Shares one pipelined muldiv unit between the two issue lanes of the
// dual-fetch PARC core. Each cycle one lane's request is granted and
// forwarded; the granted lane ID is queued in issue order, and each muldiv
// response is steered back to the lane at the head of that queue. Both the
// request and response paths are purely combinational (zero added latency).
//
// Configuration:
//   PARC_MULDIV_ARB_RR_EN  defined   -> round-robin priority between lanes
//                          undefined -> fixed priority, lane 0 wins
//
// Ports:
//   clk, reset_n                      core clock, async active-low reset
//   req{0,1}_fn/_a/_b/_val/_rdy       per-lane muldiv request handshake
//   muldivreq_msg_fn/_a/_b/_val/_rdy  request to the muldiv unit
//   muldivresp_msg_result/_val/_rdy   response from the muldiv unit
//   resp{0,1}_result/_val/_rdy        per-lane response handshake
// ---------------------------------------------------------------------------
module parc_core_muldiv_arb
    import parc_core_muldiv_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [2:0]  req0_fn,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_val,
    output logic        req0_rdy,

    input  logic [2:0]  req1_fn,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_val,
    output logic        req1_rdy,

    output logic [2:0]  muldivreq_msg_fn,
    output logic [31:0] muldivreq_msg_a,
    output logic [31:0] muldivreq_msg_b,
    output logic        muldivreq_val,
    input  logic        muldivreq_rdy,

    input  logic [63:0] muldivresp_msg_result,
    input  logic        muldivresp_val,
    output logic        muldivresp_rdy,

    output logic [63:0] resp0_result,
    output logic        resp0_val,
    input  logic        resp0_rdy,

    output logic [63:0] resp1_result,
    output logic        resp1_val,
    input  logic        resp1_rdy
);

    lane_id_t winner;
    lane_id_t prio;
    lane_id_t tag_head;
    logic     q_full;
    logic     q_empty;
    logic     issue_ok;
    logic     fire;
    logic     pop;

    // ---------------- priority ----------------
`ifdef PARC_MULDIV_ARB_RR_EN
    // After each issue the other lane gets priority for the next tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio <= LANE0;
        end else if (fire) begin
            prio <= (winner == LANE0) ? LANE1 : LANE0;
        end
    end
`else
    assign prio = LANE0;
`endif

    // ---------------- request arbitration ----------------
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave a value held (which would be a latch).
    always_comb begin
        winner = LANE0;
        if (req0_val && req1_val) begin
            winner = prio;
        end else if (req1_val) begin
            winner = LANE1;
        end
    end

    assign issue_ok      = muldivreq_rdy && !q_full;
    assign muldivreq_val = (req0_val || req1_val) && !q_full;
    assign req0_rdy      = req0_val && (winner == LANE0) && issue_ok;
    assign req1_rdy      = req1_val && (winner == LANE1) && issue_ok;
    assign fire          = muldivreq_val && muldivreq_rdy;

    assign muldivreq_msg_fn = (winner == LANE1) ? req1_fn : req0_fn;
    assign muldivreq_msg_a  = (winner == LANE1) ? req1_a  : req0_a;
    assign muldivreq_msg_b  = (winner == LANE1) ? req1_b  : req0_b;

    // ---------------- response steering ----------------
    // With nothing outstanding a response has no owner, so it is refused.
    always_comb begin
        resp0_val      = 1'b0;
        resp1_val      = 1'b0;
        muldivresp_rdy = 1'b0;
        if (!q_empty) begin
            if (tag_head == LANE0) begin
                resp0_val      = muldivresp_val;
                muldivresp_rdy = resp0_rdy;
            end else begin
                resp1_val      = muldivresp_val;
                muldivresp_rdy = resp1_rdy;
            end
        end
    end

    assign pop          = muldivresp_val && muldivresp_rdy;
    assign resp0_result = muldivresp_msg_result;
    assign resp1_result = muldivresp_msg_result;

    // ---------------- in-order tag queue ----------------
    parc_core_muldiv_arb_tagq #(
        .DEPTH (DEPTH)
    ) u_tagq (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fire),
        .push_id (winner),
        .pop     (pop),
        .full    (q_full),
        .empty   (q_empty),
        .head    (tag_head)
    );

endmodule

// File: tb/tb_parc_core_muldiv_arb.sv
// ---------------------------------------------------------------------------
// tb_parc_core_muldiv_arb
//
// Directed bench for parc_core_muldiv_arb (DEPTH = 4). The bench plays the
// muldiv unit itself: accepted requests are computed and queued, and the
// queued results are offered back one at a time. Expected lane results are
// hand-computed constants. Honors PARC_MULDIV_ARB_RR_EN for the priority
// expectations.
// ---------------------------------------------------------------------------
module tb_parc_core_muldiv_arb;
    import parc_core_muldiv_arb_pkg::*;

`ifdef PARC_MULDIV_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [2:0]  req0_fn,  req1_fn;
    logic [31:0] req0_a,   req0_b,  req1_a, req1_b;
    logic        req0_val, req0_rdy, req1_val, req1_rdy;
    logic [2:0]  muldivreq_msg_fn;
    logic [31:0] muldivreq_msg_a, muldivreq_msg_b;
    logic        muldivreq_val, muldivreq_rdy;
    logic [63:0] muldivresp_msg_result;
    logic        muldivresp_val, muldivresp_rdy;
    logic [63:0] resp0_result, resp1_result;
    logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;

    parc_core_muldiv_arb #(.DEPTH(4)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .req0_fn               (req0_fn),
        .req0_a                (req0_a),
        .req0_b                (req0_b),
        .req0_val              (req0_val),
        .req0_rdy              (req0_rdy),
        .req1_fn               (req1_fn),
        .req1_a                (req1_a),
        .req1_b                (req1_b),
        .req1_val              (req1_val),
        .req1_rdy              (req1_rdy),
        .muldivreq_msg_fn      (muldivreq_msg_fn),
        .muldivreq_msg_a       (muldivreq_msg_a),
        .muldivreq_msg_b       (muldivreq_msg_b),
        .muldivreq_val         (muldivreq_val),
        .muldivreq_rdy         (muldivreq_rdy),
        .muldivresp_msg_result (muldivresp_msg_result),
        .muldivresp_val        (muldivresp_val),
        .muldivresp_rdy        (muldivresp_rdy),
        .resp0_result          (resp0_result),
        .resp0_val             (resp0_val),
        .resp0_rdy             (resp0_rdy),
        .resp1_result          (resp1_result),
        .resp1_val             (resp1_val),
        .resp1_rdy             (resp1_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] mdq [$];     // results pending inside the emulated unit
    logic [63:0] got0 [$];    // results delivered to lane 0
    logic [63:0] got1 [$];    // results delivered to lane 1
    logic        grants [$];  // granted lane of each fire
    int          fires;
    int          seen1;
    bit          rand_mode;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioral muldiv: product, or {remainder, quotient}.
    function automatic logic [63:0] md_model(input logic [2:0] fn, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [63:0] sa, sb;
        muldiv_resp_t       r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        r  = '1;
        case (fn)
            MD_MUL: r = sa * sb;
            MD_DIV, MD_REM: if (b != 0) begin
                r.lo = $signed(a) / $signed(b);
                r.hi = $signed(a) % $signed(b);
            end
            MD_DIVU, MD_REMU: if (b != 0) begin
                r.lo = a / b;
                r.hi = a % b;
            end
            default: r = '1;
        endcase
        return r;
    endfunction

    task automatic idle_inputs();
        req0_val = 0; req0_fn = 0; req0_a = 0; req0_b = 0;
        req1_val = 0; req1_fn = 0; req1_a = 0; req1_b = 0;
        muldivreq_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
        muldivresp_val = 0; muldivresp_msg_result = 0;
    endtask

    // Entered at posedge+1; leaves at posedge+1 with the DUT released.
    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        mdq.delete(); got0.delete(); got1.delete(); grants.delete();
        fires = 0; seen1 = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Offer the unit's head result, then settle to the negedge for sampling.
    task automatic settle();
        if (mdq.size() != 0) begin
            muldivresp_msg_result = mdq[0];
            muldivresp_val        = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end else begin
            muldivresp_msg_result = '0;
            muldivresp_val        = 1'b0;
        end
        if (rand_mode) begin
            resp0_rdy = 1'($urandom_range(0, 1));
            resp1_rdy = 1'($urandom_range(0, 1));
        end
        #4;
    endtask

    // Record the handshakes that complete at the coming edge, then cross it.
    task automatic advance();
        if (muldivreq_val && muldivreq_rdy) begin
            mdq.push_back(md_model(muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b));
            grants.push_back(req1_rdy);
            fires++;
        end
        if (resp0_val && resp0_rdy) got0.push_back(resp0_result);
        if (resp1_val && resp1_rdy) got1.push_back(resp1_result);
        if (resp1_val) seen1++;
        if (muldivresp_val && muldivresp_rdy) void'(mdq.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (mdq.size() != 0 && n < budget) begin
            settle();
            advance();
            n++;
        end
        check(tag, mdq.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [63:0] exp0 [4];
        logic [63:0] exp1 [4];
        int          order [8];
        bit          accepted;
        int          waited;
        int          n;

        rand_mode = 0;
        reset_n   = 1'b0;
        idle_inputs();
        #1;
        do_reset();

        // ---- reset state, including a stray response with nothing queued
        muldivresp_val = 1'b1;
        #1;
        check("rst_stray_resp_rdy", muldivresp_rdy, 0);
        check("rst_stray_resp0_val", resp0_val, 0);
        settle();
        check("rst_req0_rdy", req0_rdy, 0);
        check("rst_req1_rdy", req1_rdy, 0);
        check("rst_mdreq_val", muldivreq_val, 0);
        check("rst_resp1_val", resp1_val, 0);
        advance();

        // ---- lane 0 only: mul 8 x 3
        req0_val = 1; req0_fn = MD_MUL; req0_a = 32'h8; req0_b = 32'h3;
        settle();
        check("t1_req0_rdy", req0_rdy, 1);
        check("t1_req1_rdy", req1_rdy, 0);
        check("t1_mdreq_a", muldivreq_msg_a, 32'h8);
        advance();
        req0_val = 0;
        drain("t1_drain", 20);
        check("t1_count", got0.size(), 1);
        check("t1_result", got0.size() > 0 ? got0[0] : '1, 64'h00000000_00000018);
        check("t1_resp1_never", seen1, 0);

        // ---- both lanes valid every cycle
        do_reset();
        req0_val = 1; req0_fn = MD_MUL; req0_a = 32'hfffffff8; req0_b = 32'h8;
        req1_val = 1; req1_fn = MD_DIV; req1_a = 32'h222;      req1_b = 32'h2a;
        repeat (4) begin
            settle();
            advance();
        end
        req0_val = 0; req1_val = 0;
        drain("t2_drain", 20);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_grant%0d", i), i < grants.size() ? 64'(grants[i]) : 64'hdead,
                  RR ? 64'(i % 2) : 64'h0);
        end
        check("t2_n_lane0", got0.size(), RR ? 2 : 4);
        check("t2_n_lane1", got1.size(), RR ? 2 : 0);
        check("t2_lane0_res", got0.size() > 0 ? got0[0] : '1, 64'hffffffff_ffffffc0);
        if (RR) begin
            check("t2_lane1_res", got1.size() > 0 ? got1[0] : '1, 64'h00000000_0000000d);
        end

        // ---- stalled lane 0 response fills the queue, then drains
        do_reset();
        resp0_rdy = 0; resp1_rdy = 0;
        req0_val = 1; req0_fn = MD_MUL; req0_a = 32'h5; req0_b = 32'h1;
        req1_val = 1; req1_fn = MD_MUL; req1_a = 32'h6; req1_b = 32'h1;
        repeat (8) begin
            settle();
            advance();
        end
        check("t3_fires", fires, 4);
        settle();
        check("t3_full_req0_rdy", req0_rdy, 0);
        check("t3_full_req1_rdy", req1_rdy, 0);
        check("t3_full_mdreq_val", muldivreq_val, 0);
        check("t3_full_resp0_val", resp0_val, 1);
        check("t3_full_mdresp_rdy", muldivresp_rdy, 0);
        advance();
        // full and popping in the same cycle: no push
        resp0_rdy = 1;
        settle();
        check("t3_pop_mdresp_rdy", muldivresp_rdy, 1);
        check("t3_nobypass_mdreq_val", muldivreq_val, 0);
        check("t3_nobypass_rdy", req0_rdy | req1_rdy, 0);
        advance();
        resp0_rdy = 0;
        settle();
        check("t3_resume_mdreq_val", muldivreq_val, 1);
        check("t3_resume_rdy", req0_rdy | req1_rdy, 1);
        advance();
        settle();
        check("t3_refull_mdreq_val", muldivreq_val, 0);
        advance();
        req0_val = 0; req1_val = 0;
        resp0_rdy = 1; resp1_rdy = 1;
        drain("t3_drain", 40);
        check("t3_n_lane0", got0.size(), RR ? 3 : 5);
        check("t3_n_lane1", got1.size(), RR ? 2 : 0);

        // ---- interleaved 0,1,1,0,0,1,1,0 with random delays and readiness
        do_reset();
        order = '{0, 1, 1, 0, 0, 1, 1, 0};
        exp0  = '{64'h000, 64'h003, 64'h004, 64'h007};
        exp1  = '{64'h101, 64'h102, 64'h105, 64'h106};
        rand_mode = 1;
        for (int k = 0; k < 8; k++) begin
            req0_val = (order[k] == 0); req0_fn = MD_MUL; req0_a = 32'(k);         req0_b = 1;
            req1_val = (order[k] == 1); req1_fn = MD_MUL; req1_a = 32'(256 + k);   req1_b = 1;
            accepted = 0;
            waited   = 0;
            while (!accepted && waited < 50) begin
                muldivreq_rdy = 1'($urandom_range(0, 1));
                settle();
                accepted = (order[k] == 0) ? req0_rdy : req1_rdy;
                advance();
                waited++;
            end
            check($sformatf("t4_issue%0d", k), accepted, 1);
        end
        req0_val = 0; req1_val = 0; muldivreq_rdy = 1;
        n = 0;
        while (got0.size() + got1.size() < 8 && n < 500) begin
            settle();
            advance();
            n++;
        end
        rand_mode = 0; resp0_rdy = 1; resp1_rdy = 1;
        check("t4_n_lane0", got0.size(), 4);
        check("t4_n_lane1", got1.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_lane0_%0d", i), i < got0.size() ? got0[i] : '1, exp0[i]);
            check($sformatf("t4_lane1_%0d", i), i < got1.size() ? got1[i] : '1, exp1[i]);
        end

        // ---- reset with three operations in flight
        do_reset();
        resp0_rdy = 0; resp1_rdy = 0;
        req0_val = 1; req0_fn = MD_MUL; req0_a = 32'h7; req0_b = 32'h7;
        repeat (3) begin
            settle();
            advance();
        end
        req0_val = 0;
        settle();
        check("t6_pre_resp0_val", resp0_val, 1);
        reset_n   = 1'b0;
        resp0_rdy = 1'b1;
        #1;
        check("t6_rst_resp0_val", resp0_val, 0);
        check("t6_rst_resp1_val", resp1_val, 0);
        check("t6_rst_mdresp_rdy", muldivresp_rdy, 0);
        do_reset();
        req1_val = 1; req1_fn = MD_MUL; req1_a = 32'h1; req1_b = 32'h1;
        settle();
        check("t6_req1_rdy", req1_rdy, 1);
        advance();
        req1_val = 0;
        drain("t6_drain", 20);
        check("t6_n_lane0", got0.size(), 0);
        check("t6_n_lane1", got1.size(), 1);
        check("t6_result", got1.size() > 0 ? got1[0] : '1, 64'h00000000_00000001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
